// File: rtl/pp_row_accum_if.sv
`default_nettype none
// ============================================================================
// Module  : pp_row_accum_if
// Purpose : Row-in / product-out handshake bundle for the row accumulator.
// Rev     : 1.0
// ============================================================================
interface pp_row_accum_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);
    logic                   clr;
    logic [WIDTH-1:0]       pp_row;
    logic                   pp_valid;
    logic                   pp_ready;
    logic [2*WIDTH-1:0]     C;
    logic                   c_valid;
    logic                   c_ready;
    logic                   busy;
    logic [CNT_W-1:0]       row_cnt;

    modport master (
        output clr, pp_row, pp_valid, c_ready,
        input  pp_ready, C, c_valid, busy, row_cnt
    );

    modport slave (
        input  clr, pp_row, pp_valid, c_ready,
        output pp_ready, C, c_valid, busy, row_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pp_row_accum.sv
`default_nettype none
// ============================================================================
// Module  : pp_row_accum
// Purpose : Iterative shift-and-add of partial-product rows into a 2*WIDTH product.
// Rev     : 1.0
// ============================================================================
module pp_row_accum #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  wire logic       CLK,
    input  wire logic       rst,
    pp_row_accum_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_ROW = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q,   acc_d;
    logic [2*WIDTH-1:0]   c_q,     c_d;
    logic [CNT_W-1:0]     row_cnt_q, row_cnt_d;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_shift;
    logic [2*WIDTH-1:0]   w_sum;

    // clr blocks acceptance in the same cycle so an aborted row never lands
    assign w_ready  = (state_q == ST_ACC) & ~bus.clr;
    assign w_accept = w_ready & bus.pp_valid;
    assign w_last   = (row_cnt_q == C_LAST_ROW);
    assign w_shift  = {{WIDTH{1'b0}}, bus.pp_row} << row_cnt_q;
    assign w_sum    = acc_q + w_shift;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            c_q       <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        c_d       = c_q;
        row_cnt_d = row_cnt_q;

        case (state_q)
            ST_ACC: begin
                if (w_accept) begin
                    acc_d     = w_sum;
                    row_cnt_d = row_cnt_q + CNT_W'(1);
                    if (w_last) begin
                        c_d       = w_sum;
                        state_d   = ST_DONE;
                        row_cnt_d = '0;
                    end
                end
            end
            ST_DONE: begin
                if (bus.c_ready) begin
                    acc_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        // C is deliberately left untouched so the last product stays visible
        if (bus.clr) begin
            acc_d     = '0;
            row_cnt_d = '0;
            state_d   = ST_ACC;
        end
    end

    assign bus.pp_ready = w_ready;
    assign bus.c_valid  = (state_q == ST_DONE);
    assign bus.C        = c_q;
    assign bus.busy     = (state_q == ST_ACC) & (row_cnt_q != '0);
    assign bus.row_cnt  = row_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_row_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_pp_row_accum
// Purpose : Scoreboard bench for pp_row_accum.
// Rev     : 1.0
// ============================================================================
module tb_pp_row_accum;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    pp_row_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pp_row_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    logic [63:0] sb [$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output side: a product retires on an edge with c_valid & c_ready
    always @(negedge CLK) begin
        if (!rst && !bus.clr && bus.c_valid && bus.c_ready) begin
            if (sb.size() == 0)
                chk("sb_unexpected", {63'b0, bus.c_valid}, 64'd0);
            else
                chk("C", bus.C, sb.pop_front());
        end
    end

    task automatic send_row(input logic [31:0] row);
        int   waited;
        logic acc;
        waited = 0;
        bus.pp_row   = row;
        bus.pp_valid = 1'b1;
        forever begin
            #1;
            acc = bus.pp_ready;
            @(posedge CLK); #1;
            if (acc) break;
            waited++;
            if (waited > 100) begin
                chk("row_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic send_rows(input logic [31:0] a, input logic [31:0] b,
                             input int n, input bit bubble);
        logic [CNT_W-1:0] rc;
        for (int i = 0; i < n; i++) begin
            if (bubble && (cyc % 3 == 2)) begin
                bus.pp_valid = 1'b0;
                rc = bus.row_cnt;
                @(posedge CLK); #1;
                chk("bubble_hold", bus.row_cnt, rc);
            end
            cyc++;
            chk("row_cnt", bus.row_cnt, i);
            if (i == WIDTH - 1)
                chk("cv_before_last", bus.c_valid, 0);
            send_row(b[i] ? a : 32'h0);
            if (i == WIDTH - 1) begin
                chk("cvalid_lat", bus.c_valid, 1);
                chk("cnt_wrap", bus.row_cnt, 0);
                chk("ppr_done", bus.pp_ready, 0);
            end
        end
    endtask

    task automatic product(input logic [31:0] a, input logic [31:0] b, input bit bubble);
        sb.push_back({32'h0, a} * {32'h0, b});
        send_rows(a, b, WIDTH, bubble);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] e;
        bus.clr      = 1'b0;
        bus.pp_valid = 1'b0;
        bus.pp_row   = '0;
        bus.c_ready  = 1'b1;

        #12;
        chk("rst_C", bus.C, 0);
        chk("rst_cvalid", bus.c_valid, 0);
        chk("rst_rowcnt", bus.row_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(posedge CLK); #1;
        chk("ppr_after_rst", bus.pp_ready, 1);

        // basic 3*5
        product(32'd3, 32'd5, 1'b0);
        bus.pp_valid = 1'b0;
        @(posedge CLK); #1;
        chk("retired1", bus.c_valid, 0);

        // max operands
        product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        bus.pp_valid = 1'b0;
        @(posedge CLK); #1;

        // bubbles plus held output under backpressure, rows still offered in DONE
        bus.c_ready = 1'b0;
        e = {32'h0, 32'h1234_5678} * {32'h0, 32'h9ABC_DEF0};
        product(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        repeat (5) begin
            @(posedge CLK); #1;
            chk("C_hold", bus.C, e);
            chk("cv_hold", bus.c_valid, 1);
            chk("ppr_hold", bus.pp_ready, 0);
        end
        bus.c_ready = 1'b1;
        @(posedge CLK); #1;
        chk("retire_first", bus.c_valid, 0);
        chk("C_kept", bus.C, e);
        bus.pp_valid = 1'b0;

        // back-to-back with c_ready tied high
        product(32'd7, 32'd9, 1'b0);
        @(posedge CLK); #1;
        chk("one_done_ppr", bus.pp_ready, 1);
        chk("one_done_cv", bus.c_valid, 0);
        product(32'h0001_0000, 32'h0001_0000, 1'b0);
        bus.pp_valid = 1'b0;
        @(posedge CLK); #1;

        // clr mid-product; row offered alongside clr must be dropped
        send_rows(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0);
        chk("busy_mid", bus.busy, 1);
        bus.clr      = 1'b1;
        bus.pp_row   = 32'hFFFF_FFFF;
        bus.pp_valid = 1'b1;
        #1;
        chk("ppr_clr", bus.pp_ready, 0);
        @(posedge CLK); #1;
        bus.clr      = 1'b0;
        bus.pp_valid = 1'b0;
        chk("clr_rowcnt", bus.row_cnt, 0);
        chk("clr_busy", bus.busy, 0);
        product(32'd2, 32'd3, 1'b0);
        bus.pp_valid = 1'b0;
        @(posedge CLK); #1;

        // asynchronous reset between edges
        send_rows(32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 1'b0);
        bus.pp_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_C", bus.C, 0);
        chk("arst_cvalid", bus.c_valid, 0);
        chk("arst_rowcnt", bus.row_cnt, 0);
        chk("arst_busy", bus.busy, 0);
        @(negedge CLK);
        rst = 1'b0;
        @(posedge CLK); #1;
        product(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        bus.pp_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
